// File: rtl/data_mem_responder_pkg.sv
// Shared types and constants for the CPU data-memory responder:
// controller state encoding, read-path select codes and MMIO offsets.
package cpu_pkg;

  typedef enum logic {
    MEM_CLEAR = 1'b0,
    MEM_RUN   = 1'b1
  } mem_state_t;

  // Which source feeds the read-data output this cycle.
  typedef enum logic [1:0] {
    RD_ZERO = 2'd0,
    RD_RAM  = 2'd1,
    RD_MMIO = 2'd2
  } rd_sel_t;

  // Offsets inside the MMIO window.
  localparam logic [1:0] MMIO_GPIO_OUT = 2'd0;
  localparam logic [1:0] MMIO_GPIO_IN  = 2'd1;
  localparam logic [1:0] MMIO_TICK     = 2'd2;
  localparam logic [1:0] MMIO_RSVD     = 2'd3;

  // Number of decoded registers in the MMIO window.
  localparam int MMIO_SPAN = 4;

endpackage

// File: rtl/data_mem_responder_if.sv
// CPU data-memory port as seen from both ends: the CPU (master) drives
// address, write data and write strobe; the responder (slave) returns
// read data one cycle after the address is sampled.
interface data_mem_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wData;
  logic              write;
  logic [DATA_W-1:0] rData;

  modport master (
    output addr,
    output wData,
    output write,
    input  rData
  );

  modport slave (
    input  addr,
    input  wData,
    input  write,
    output rData
  );

endinterface

// File: rtl/data_mem_responder_ram.sv
// Single-port synchronous RAM, read-first: a read and a write to the same
// address on the same edge return the data held before the write.
// Contents are never reset.
module ram_sp #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wData,
  output logic [DATA_W-1:0] rData
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rData_r;

  // Storage write and registered read-first read port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wData;
    end
    rData_r <= mem_r[addr];
  end

  assign rData = rData_r;

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the CPU data-memory port. Backs 2**ADDR_W bytes of
// synchronous RAM plus a four-register MMIO window at MMIO_BASE
// (GPIO out, synchronised GPIO in, free-running tick counter, reserved).
// Build option MEM_CLEAR_ON_RESET_EN: after every reset the RAM below
// MMIO_BASE is swept to zero, one address per cycle, while _oBusy holds
// the CPU in reset. Without it the responder starts serving immediately
// and _oBusy is tied low.
module data_mem_responder
  import cpu_pkg::*;
#(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] MMIO_BASE = 8'hFC
) (
  input  logic                 _iClk,
  input  logic                 _iReset,
  data_mem_responder_if.slave  bus,
  input  logic [DATA_W-1:0]    _iGpioIn,
  output logic [DATA_W-1:0]    _oGpioOut,
  output logic                 _oBusy
);

`ifdef MEM_CLEAR_ON_RESET_EN
  localparam mem_state_t RESET_STATE = MEM_CLEAR;
`else
  localparam mem_state_t RESET_STATE = MEM_RUN;
`endif

  mem_state_t        state_r;
  mem_state_t        stateNext_s;
  rd_sel_t           rdSel_r;
  rd_sel_t           rdSelNext_s;

  logic [ADDR_W-1:0] offFull_s;
  logic [1:0]        mmioOff_s;
  logic              isMmio_s;
  logic              offInRange_s;
  logic              cpuWrEn_s;

  logic              ramWe_s;
  logic [ADDR_W-1:0] ramAddr_s;
  logic [DATA_W-1:0] ramWData_s;
  logic [DATA_W-1:0] ramRData_s;

  logic [DATA_W-1:0] gpioOut_r;
  logic [DATA_W-1:0] gpioOutNext_s;
  logic [DATA_W-1:0] gpioSync1_r;
  logic [DATA_W-1:0] gpioSync2_r;
  logic [DATA_W-1:0] tick_r;
  logic [DATA_W-1:0] tickNext_s;
  logic [DATA_W-1:0] mmioData_r;
  logic [DATA_W-1:0] mmioRdNext_s;

`ifdef MEM_CLEAR_ON_RESET_EN
  logic [ADDR_W-1:0] clrAddr_r;
  logic [ADDR_W-1:0] clrAddrNext_s;
  logic              busy_r;
`endif

  // Address decode: MMIO window membership and offset inside it.
  always_comb begin
    offFull_s    = bus.addr - MMIO_BASE;
    isMmio_s     = (bus.addr >= MMIO_BASE);
    offInRange_s = (offFull_s < ADDR_W'(MMIO_SPAN));
    mmioOff_s    = offFull_s[1:0];
    cpuWrEn_s    = bus.write && (state_r == MEM_RUN);
  end

  // Controller next state and clear-sweep address.
  always_comb begin
    stateNext_s = state_r;
`ifdef MEM_CLEAR_ON_RESET_EN
    clrAddrNext_s = clrAddr_r;
    case (state_r)
      MEM_CLEAR: begin
        if (clrAddr_r == (MMIO_BASE - ADDR_W'(1))) begin
          stateNext_s   = MEM_RUN;
          clrAddrNext_s = '0;
        end else begin
          stateNext_s   = MEM_CLEAR;
          clrAddrNext_s = clrAddr_r + ADDR_W'(1);
        end
      end
      MEM_RUN: begin
        stateNext_s = MEM_RUN;
      end
      default: begin
        stateNext_s   = RESET_STATE;
        clrAddrNext_s = '0;
      end
    endcase
`else
    case (state_r)
      MEM_RUN: stateNext_s = MEM_RUN;
      default: stateNext_s = MEM_RUN;
    endcase
`endif
  end

  // Controller state register; reset always restarts any sweep from 0.
  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      state_r   <= RESET_STATE;
`ifdef MEM_CLEAR_ON_RESET_EN
      clrAddr_r <= '0;
      busy_r    <= 1'b1;
`endif
    end else begin
      state_r   <= stateNext_s;
`ifdef MEM_CLEAR_ON_RESET_EN
      clrAddr_r <= clrAddrNext_s;
      busy_r    <= (stateNext_s == MEM_CLEAR);
`endif
    end
  end

  // RAM port mux: the clear sweep owns the port while it runs, else the CPU.
  always_comb begin
    ramWe_s    = cpuWrEn_s && !isMmio_s;
    ramAddr_s  = bus.addr;
    ramWData_s = bus.wData;
`ifdef MEM_CLEAR_ON_RESET_EN
    if (state_r == MEM_CLEAR) begin
      ramWe_s    = 1'b1;
      ramAddr_s  = clrAddr_r;
      ramWData_s = '0;
    end else begin
      ramWe_s    = cpuWrEn_s && !isMmio_s;
      ramAddr_s  = bus.addr;
      ramWData_s = bus.wData;
    end
`endif
  end

  ram_sp #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk   (_iClk),
    .we    (ramWe_s),
    .addr  (ramAddr_s),
    .wData (ramWData_s),
    .rData (ramRData_s)
  );

  // MMIO write side: GPIO out update and tick clear/increment.
  always_comb begin
    gpioOutNext_s = gpioOut_r;
    tickNext_s    = tick_r;
    if (cpuWrEn_s && isMmio_s && offInRange_s && (mmioOff_s == MMIO_GPIO_OUT)) begin
      gpioOutNext_s = bus.wData;
    end else begin
      gpioOutNext_s = gpioOut_r;
    end
    if (cpuWrEn_s && isMmio_s && offInRange_s && (mmioOff_s == MMIO_TICK)) begin
      tickNext_s = '0;
    end else if (state_r == MEM_RUN) begin
      tickNext_s = tick_r + DATA_W'(1'b1);
    end else begin
      tickNext_s = tick_r;
    end
  end

  // MMIO read side: pick the source for the cycle after the address sample.
  // The tick value returned is the one the counter holds after this edge.
  always_comb begin
    rdSelNext_s  = RD_ZERO;
    mmioRdNext_s = '0;
    if (state_r == MEM_RUN) begin
      if (isMmio_s) begin
        rdSelNext_s = RD_MMIO;
        if (offInRange_s) begin
          case (mmioOff_s)
            MMIO_GPIO_OUT: mmioRdNext_s = gpioOut_r;
            MMIO_GPIO_IN:  mmioRdNext_s = gpioSync2_r;
            MMIO_TICK:     mmioRdNext_s = tickNext_s;
            MMIO_RSVD:     mmioRdNext_s = '0;
            default:       mmioRdNext_s = '0;
          endcase
        end else begin
          mmioRdNext_s = '0;
        end
      end else begin
        rdSelNext_s = RD_RAM;
      end
    end else begin
      rdSelNext_s = RD_ZERO;
    end
  end

  // MMIO registers, GPIO input synchroniser and registered read select.
  always_ff @(posedge _iClk or negedge _iReset) begin
    if (!_iReset) begin
      gpioOut_r   <= '0;
      gpioSync1_r <= '0;
      gpioSync2_r <= '0;
      tick_r      <= '0;
      mmioData_r  <= '0;
      rdSel_r     <= RD_ZERO;
    end else begin
      gpioOut_r   <= gpioOutNext_s;
      gpioSync1_r <= _iGpioIn;
      gpioSync2_r <= gpioSync1_r;
      tick_r      <= tickNext_s;
      mmioData_r  <= mmioRdNext_s;
      rdSel_r     <= rdSelNext_s;
    end
  end

  // Read-data mux between RAM output and MMIO holding register.
  always_comb begin
    bus.rData = '0;
    case (rdSel_r)
      RD_RAM:  bus.rData = ramRData_s;
      RD_MMIO: bus.rData = mmioData_r;
      RD_ZERO: bus.rData = '0;
      default: bus.rData = '0;
    endcase
  end

  assign _oGpioOut = gpioOut_r;

`ifdef MEM_CLEAR_ON_RESET_EN
  assign _oBusy = busy_r;
`else
  assign _oBusy = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder. Stimulus pushes the expected
// read data and GPIO output into a queue; a monitor on the falling edge
// pops and compares. Expectations come from a byte-array memory model,
// a cycle-count tick model and a settle-time model of the GPIO input.
module tb_data_mem_responder;

  localparam logic [7:0] MMIO_BASE = 8'hFC;
`ifdef MEM_CLEAR_ON_RESET_EN
  localparam logic [31:0] EXP_BUSY_RST = 32'd1;
  localparam logic [31:0] EXP_BUSY_CYC = 32'd252;
`else
  localparam logic [31:0] EXP_BUSY_RST = 32'd0;
  localparam logic [31:0] EXP_BUSY_CYC = 32'd0;
`endif

  typedef struct {
    int         due;
    logic       chk;
    logic [7:0] exp;
    logic [7:0] expGpio;
    string      name;
  } item_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] gpioIn;
  logic [7:0] gpioOut;
  logic       busy;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) dm ();

  data_mem_responder #(.ADDR_W(8), .DATA_W(8), .MMIO_BASE(8'hFC)) dut (
    ._iClk     (clk),
    ._iReset   (rstN),
    .bus       (dm.slave),
    ._iGpioIn  (gpioIn),
    ._oGpioOut (gpioOut),
    ._oBusy    (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [7:0] memV [256];
  bit         memK [256];
  logic [7:0] gpioOutM;
  logic [7:0] gpioInM;
  int         gpioChg;
  int         tickBase;
  item_t      q [$];
  item_t      mi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One bus cycle: drive at the falling edge, predict what the next edge returns.
  task automatic stepX(input logic [7:0] a, input logic [7:0] d, input logic w,
                       input string nm, input logic ovr, input logic [7:0] ovrExp);
    item_t it;
    int k;
    logic [7:0] off;
    @(negedge clk);
    dm.addr = a; dm.wData = d; dm.write = w;
    k = cyc + 1;
    it.due = k; it.name = nm; it.chk = 1'b0; it.exp = 8'h00;
    if (a >= MMIO_BASE) begin
      off = a - MMIO_BASE;
      if (w && off == 8'd2) tickBase = k;
      it.chk = 1'b1;
      case (off)
        8'd0: it.exp = gpioOutM;
        8'd1: begin it.exp = gpioInM; it.chk = (k >= gpioChg + 3); end
        8'd2: it.exp = 8'(k - tickBase);
        default: it.exp = 8'h00;
      endcase
      if (w && off == 8'd0) gpioOutM = d;
    end else begin
      it.chk = memK[a];
      it.exp = memV[a];
      if (w) begin memV[a] = d; memK[a] = 1'b1; end
    end
    if (ovr) begin it.chk = 1'b1; it.exp = ovrExp; end
    it.expGpio = gpioOutM;
    q.push_back(it);
  endtask

  task automatic step(input logic [7:0] a, input logic [7:0] d, input logic w, input string nm);
    stepX(a, d, w, nm, 1'b0, 8'h00);
  endtask

  task automatic setGpio(input logic [7:0] v);
    @(negedge clk);
    dm.write = 1'b0;
    gpioIn = v; gpioInM = v; gpioChg = cyc;
  endtask

  task automatic drain();
    dm.write = 1'b0;
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d items left", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  // Count busy cycles from the release falling edge; leaves tick base at the fall edge.
  task automatic waitBusy(input string nm);
    int cnt = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      cnt++;
      @(negedge clk);
    end
    chk(nm, cnt, EXP_BUSY_CYC);
    tickBase = cyc;
`ifdef MEM_CLEAR_ON_RESET_EN
    for (int i = 0; i < 252; i++) begin memV[i] = 8'h00; memK[i] = 1'b1; end
`endif
  endtask

  task automatic doReset(input string nm);
    drain();
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    chk({nm, "_rdata"}, dm.rData, 32'd0);
    chk({nm, "_gpio"}, gpioOut, 32'd0);
    chk({nm, "_busy"}, busy, EXP_BUSY_RST);
    rstN = 1'b1;
    gpioOutM = 8'h00;
    gpioChg = cyc;
    waitBusy({nm, "_busycyc"});
  endtask

  // Monitor: compare whenever a predicted response is due.
  always @(negedge clk) begin
    if (rstN) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        mi = q.pop_front();
        if (mi.due != cyc) begin
          total++; bad++;
          $display("FAIL late_%s: due %0d now %0d", mi.name, mi.due, cyc);
        end
        if (mi.chk) chk({"rdata_", mi.name}, dm.rData, mi.exp);
        chk({"gpio_", mi.name}, gpioOut, mi.expGpio);
        chk({"busy_", mi.name}, busy, 32'd0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] a;
    int r;
    dm.addr = 8'h00; dm.wData = 8'h00; dm.write = 1'b0;
    gpioIn = 8'h00; gpioInM = 8'h00; gpioChg = -100;
    gpioOutM = 8'h00; tickBase = 0;
    for (int i = 0; i < 256; i++) begin memV[i] = 8'h00; memK[i] = 1'b0; end

    doReset("por");

    // Cleared RAM reads back zero (only predicted when the sweep exists).
    step(8'h00, 8'h00, 1'b0, "rd00");
    step(8'h7F, 8'h00, 1'b0, "rd7f");
    step(8'hFB, 8'h00, 1'b0, "rdfb");

    // Tick after 300 running cycles, then clear-by-write.
    for (int i = 0; i < 400 && cyc < tickBase + 298; i++) step(8'h00, 8'h00, 1'b0, "idle");
    stepX(8'hFE, 8'h00, 1'b0, "tick300", 1'b1, 8'h2C);
    step(8'hFE, 8'hFE, 1'b1, "tick_wr");
    stepX(8'hFE, 8'h00, 1'b0, "tick_clr", 1'b1, 8'h01);

    // RAM write then read, and read-during-write.
    step(8'h10, 8'hA5, 1'b1, "wr10");
    stepX(8'h10, 8'h00, 1'b0, "rd10", 1'b1, 8'hA5);
    step(8'h20, 8'h11, 1'b1, "wr20a");
    stepX(8'h20, 8'h22, 1'b1, "rdw20", 1'b1, 8'h11);
    stepX(8'h20, 8'h00, 1'b0, "rd20", 1'b1, 8'h22);

    // GPIO out / in and reserved register.
    step(8'hFC, 8'h3C, 1'b1, "gpo_wr");
    step(8'hFC, 8'h00, 1'b0, "gpo_rd");
    setGpio(8'h5A);
    step(8'h00, 8'h00, 1'b0, "idle");
    step(8'h00, 8'h00, 1'b0, "idle");
    stepX(8'hFD, 8'h00, 1'b0, "gpi", 1'b1, 8'h5A);
    step(8'hFF, 8'h99, 1'b1, "rsv_wr");
    step(8'hFF, 8'h00, 1'b0, "rsv_rd");

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        setGpio(8'($urandom));
      end else begin
        if (r < 25) a = MMIO_BASE + 8'($urandom_range(0, 3));
        else        a = 8'($urandom_range(0, 31));
        step(a, 8'($urandom), 1'($urandom_range(0, 1)), "rnd");
      end
    end

`ifdef MEM_CLEAR_ON_RESET_EN
    // Reset again mid-sweep while the CPU tries to write 0x05.
    drain();
    rstN = 1'b0;
    @(negedge clk);
    rstN = 1'b1;
    for (int i = 0; i < 100; i++) begin
      dm.addr = 8'h05; dm.wData = 8'h77; dm.write = 1'b1;
      @(negedge clk);
    end
    rstN = 1'b0;
    @(negedge clk);
    chk("midsweep_busy", busy, 32'd1);
    rstN = 1'b1;
    gpioOutM = 8'h00;
    gpioChg = cyc;
    waitBusy("midsweep_busycyc");
    dm.write = 1'b0;
    stepX(8'h05, 8'h00, 1'b0, "rd05", 1'b1, 8'h00);
`endif

    // Final reset: outputs clear, RAM retained or re-swept as the build dictates.
    doReset("rst2");
    step(8'h10, 8'h00, 1'b0, "rd10_post");
    step(8'hFC, 8'h00, 1'b0, "gpo_post");
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
